// File: rtl/core88_sram.sv
// core88_sram: 8-bit CPU byte port onto a 16-bit asynchronous SRAM, with a one-word read buffer.
// Latency: buffer hit 0 cycles; read miss or write WAIT+1 cycles (WAIT of 0 behaves as 1).
// Backpressure: locked=0 stalls the CPU, which holds address/wdata/wreq until locked returns to 1.
// Build option: define CORE88_SRAM_ROM_EN to write-protect 20'hF0000-20'hFFFFF (writes skip the SRAM).
module core88_sram #(
    parameter int WAIT = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [19:0] address,
    input  logic [7:0]  wdata,
    input  logic        wreq,
    output logic [7:0]  rdata,
    output logic        locked,
    output logic [18:0] sram_a,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [1:0]  sram_be
);

    // A zero-length access makes no sense for an async SRAM; clamp to one cycle.
    localparam int WAIT_EFF = (WAIT < 1) ? 1 : WAIT;
    localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // SRAM access cycle counter; the access ends when it reaches WAIT_EFF-1.
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    // One-word read buffer.
    logic             buf_vld;
    logic [18:0]      buf_tag;
    logic [15:0]      buf_dat;
    logic             hit;

    // Write captured in IDLE so the SRAM cycle does not depend on the CPU bus.
    logic [18:0]      wr_addr;
    logic             wr_lane;
    logic [7:0]       wr_byte;

    // Write landing in the protected region (always 0 when protection is not built).
    logic             rom_wr;

`ifdef CORE88_SRAM_ROM_EN
    assign rom_wr = (address[19:16] == 4'hF);
`else
    assign rom_wr = 1'b0;
`endif

    assign cnt_last  = (cnt == CNT_LAST);
    assign hit       = buf_vld && (buf_tag == address[19:1]);
    assign rdata     = hit ? (address[0] ? buf_dat[15:8] : buf_dat[7:0]) : 8'h00;
    // Byte replicated on both lanes; sram_be selects which lane the SRAM takes.
    assign sram_dq_o = {wr_byte, wr_byte};

    // Next-state decode and SRAM strobes; strobes are pure state decode so reset kills them at once.
    always_comb begin
        state_nxt = state;
        locked    = 1'b0;
        sram_oe   = 1'b0;
        sram_we   = 1'b0;
        sram_be   = 2'b00;
        sram_a    = address[19:1];
        case (state)
            IDLE: begin
                locked = !wreq && hit;
                if (wreq) begin
                    // Writes win over a pending read miss.
                    state_nxt = rom_wr ? WDONE : WR;
                end else if (!hit) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                sram_oe = 1'b1;
                sram_be = 2'b11;
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                sram_we = 1'b1;
                sram_a  = wr_addr;
                sram_be = wr_lane ? 2'b10 : 2'b01;
                if (cnt_last) begin
                    state_nxt = WDONE;
                end
            end
            WDONE: begin
                // One-cycle acknowledge so the CPU can advance past the store.
                locked    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and access counter; counter restarts from 0 on every RD/WR entry.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == RD) || (state == WR)) begin
                if (!cnt_last) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Buffer valid: cleared by reset, set when a read fill completes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            buf_vld <= 1'b0;
        end else if ((state == RD) && cnt_last) begin
            buf_vld <= 1'b1;
        end
    end

    // Buffer tag/data: filled on read completion, patched by a write to the same word.
    always_ff @(posedge clock) begin
        if (resetn) begin
            if ((state == RD) && cnt_last) begin
                buf_tag <= address[19:1];
                buf_dat <= sram_dq_i;
            end else if ((state == WR) && cnt_last && (buf_tag == wr_addr)) begin
                if (wr_lane) begin
                    buf_dat[15:8] <= wr_byte;
                end else begin
                    buf_dat[7:0] <= wr_byte;
                end
            end
        end
    end

    // Capture the CPU write when it is accepted in IDLE.
    always_ff @(posedge clock) begin
        if (resetn && (state == IDLE) && wreq) begin
            wr_addr <= address[19:1];
            wr_lane <= address[0];
            wr_byte <= wdata;
        end
    end

endmodule

// File: tb/tb_core88_sram.sv
// tb_core88_sram: random and directed CPU traffic against a word-level memory model.
// Latency: expectations are whole-transaction cycle counts (hit 0, miss/write WAIT+1).
// Backpressure: each transaction holds its inputs until locked is seen high.
module tb_core88_sram;

    localparam int W  = 2;
    localparam int WE = (W < 1) ? 1 : W;

    logic        clock = 1'b0;
    logic        resetn;
    logic [19:0] address;
    logic [7:0]  wdata;
    logic        wreq;
    logic [7:0]  rdata;
    logic        locked;
    logic [18:0] sram_a;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_oe;
    logic        sram_we;
    logic [1:0]  sram_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    core88_sram #(.WAIT(W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .address   (address),
        .wdata     (wdata),
        .wreq      (wreq),
        .rdata     (rdata),
        .locked    (locked),
        .sram_a    (sram_a),
        .sram_dq_o (sram_dq_o),
        .sram_dq_i (sram_dq_i),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_be   (sram_be)
    );

    // Power-up SRAM contents, with the two words the directed checks rely on.
    function automatic logic [15:0] init_word(input logic [18:0] a);
        if (a == 19'h7FFF8) return 16'hA5EA;
        if (a == 19'h00080) return 16'h0000;
        return a[15:0] ^ 16'h5AC3;
    endfunction

    // SRAM device model.
    logic [15:0] sram_mem [0:524287];
    bit          mem_ready = 1'b0;
    assign sram_dq_i = sram_oe ? sram_mem[sram_a] : 16'h0000;

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 524288; i++) sram_mem[i] = init_word(19'(i));
            mem_ready = 1'b1;
        end
        if (sram_we) begin
            if (sram_be[0]) sram_mem[sram_a][7:0]  = sram_dq_o[7:0];
            if (sram_be[1]) sram_mem[sram_a][15:8] = sram_dq_o[15:8];
        end
    end

    // Reference model: memory contents plus which word the read buffer holds.
    logic [15:0] ref_mem [logic [18:0]];
    bit          mv = 1'b0;
    logic [18:0] mtag = '0;

    function automatic logic [15:0] ref_word(input logic [18:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic void ref_write(input logic [19:0] a, input logic [7:0] d);
        logic [15:0] w;
        w = ref_word(a[19:1]);
        if (a[0]) w[15:8] = d;
        else      w[7:0]  = d;
        ref_mem[a[19:1]] = w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One CPU transaction, started at a falling edge; returns at a falling edge.
    task automatic do_op(input bit wr, input logic [19:0] a, input logic [7:0] d);
        bit          rom, hit, done, both;
        int          lat, oe_n, we_n;
        logic [1:0]  be_s;
        logic [18:0] a_s;
        logic [15:0] dq_s, w;
        logic [7:0]  rd_s;
`ifdef CORE88_SRAM_ROM_EN
        rom = wr && (a >= 20'hF0000);
`else
        rom = 1'b0;
`endif
        hit = !wr && mv && (mtag == a[19:1]);
        address = a;
        wdata   = d;
        wreq    = wr;
        #1;
        lat = 0; oe_n = 0; we_n = 0; both = 0; done = 0;
        be_s = '0; a_s = '0; dq_s = '0; rd_s = '0;
        while (!done) begin
            if (sram_oe && sram_we) both = 1'b1;
            if (sram_oe) begin
                if (oe_n == 0) begin be_s = sram_be; a_s = sram_a; end
                oe_n++;
            end
            if (sram_we) begin
                if (we_n == 0) begin be_s = sram_be; a_s = sram_a; dq_s = sram_dq_o; end
                we_n++;
            end
            if (locked || lat >= 20) begin
                done = 1'b1;
                rd_s = rdata;
            end else begin
                @(negedge clock);
                #1;
                lat++;
            end
        end
        w = ref_word(a[19:1]);
        if (wr) begin
            chk("wr_latency", lat, rom ? 1 : WE + 1);
            chk("wr_we_cycles", we_n, rom ? 0 : WE);
            chk("wr_oe_cycles", oe_n, 0);
            if (!rom) begin
                chk("wr_be", be_s, a[0] ? 2'b10 : 2'b01);
                chk("wr_word_addr", a_s, a[19:1]);
                chk("wr_dq", dq_s, {d, d});
                ref_write(a, d);
            end
        end else begin
            chk("rd_latency", lat, hit ? 0 : WE + 1);
            chk("rd_oe_cycles", oe_n, hit ? 0 : WE);
            chk("rd_data", rd_s, a[0] ? w[15:8] : w[7:0]);
            if (!hit) begin
                chk("rd_be", be_s, 2'b11);
                chk("rd_word_addr", a_s, a[19:1]);
            end
            mv   = 1'b1;
            mtag = a[19:1];
        end
        chk("oe_we_overlap", both, 0);
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [19:0] bases [4];
        logic [19:0] ra;
        bases[0] = 20'h00100;
        bases[1] = 20'h0FFFC;
        bases[2] = 20'hEFFFC;
        bases[3] = 20'hFFFFA;

        resetn  = 1'b0;
        address = 20'hFFFF0;
        wdata   = 8'h00;
        wreq    = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("reset_locked", locked, 0);
        chk("reset_oe", sram_oe, 0);
        chk("reset_we", sram_we, 0);
        chk("reset_be", sram_be, 2'b00);

        // Fill from the top of memory, then hit on the other lane.
        do_op(1'b0, 20'hFFFF0, 8'h00);
        do_op(1'b0, 20'hFFFF1, 8'h00);

        // Buffered word patched by a write, then read back without an SRAM read.
        do_op(1'b0, 20'h00100, 8'h00);
        do_op(1'b1, 20'h00100, 8'h77);
        do_op(1'b0, 20'h00100, 8'h00);

        // Back-to-back bytes of a 16-bit store across a word boundary.
        do_op(1'b1, 20'h00101, 8'h34);
        do_op(1'b1, 20'h00102, 8'h12);
        do_op(1'b0, 20'h00101, 8'h00);

        // Write into the optionally protected region, and the last byte of memory.
        do_op(1'b1, 20'hF0010, 8'hC7);
        do_op(1'b0, 20'hF0010, 8'h00);
        do_op(1'b0, 20'hFFFFF, 8'h00);

        // Reset in the second WR cycle aborts the store and drops the buffer.
        do_op(1'b0, 20'h00100, 8'h00);
        address = 20'h00100;
        wdata   = 8'h5A;
        wreq    = 1'b1;
        @(negedge clock); #1;
        chk("abort_wr_c1_we", sram_we, 1);
        @(negedge clock); #1;
        chk("abort_wr_c2_we", sram_we, 1);
        resetn = 1'b0;
        @(negedge clock); #1;
        chk("abort_we_low", sram_we, 0);
        chk("abort_oe_low", sram_oe, 0);
        resetn = 1'b1;
        wreq   = 1'b0;
        #1;
        chk("abort_valid_cleared", locked, 0);
        mv = 1'b0;
        ref_write(20'h00100, 8'h5A);
        do_op(1'b0, 20'h00100, 8'h00);

        // Random mix over a few small windows so hits, misses and coherence all occur.
        for (int k = 0; k < 300; k++) begin
            ra = bases[$urandom_range(0, 3)] + 20'($urandom_range(0, 5));
            do_op($urandom_range(0, 2) == 0, ra, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core88_sram.md
CORE88_SRAM -- requirements
Module: core88_sram

Interface
REQ-001 Parameter WAIT, default 2, SHALL set the number of clock cycles in each external SRAM access; a value of 0 SHALL be treated as 1.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 resetn  input  1  reset: synchronous, active-low, sampled on the clock rising edge.
REQ-004 address  input  20  CPU byte address.
REQ-005 wdata  input  8  CPU write byte.
REQ-006 wreq  input  1  CPU write request, level.
REQ-007 rdata  output  8  read byte returned to the CPU, combinational.
REQ-008 locked  output  1  CPU advance enable; the CPU holds address, wdata and wreq stable while locked is 0.
REQ-009 sram_a  output  19  SRAM word address.
REQ-010 sram_dq_o  output  16  SRAM write data.
REQ-011 sram_dq_i  input  16  SRAM read data.
REQ-012 sram_oe  output  1  SRAM output enable, active-high.
REQ-013 sram_we  output  1  SRAM write enable, active-high.
REQ-014 sram_be  output  2  SRAM byte lane enables; bit 0 = [7:0], bit 1 = [15:8].

Function
REQ-015 The block SHALL hold a one-word read buffer: valid bit, 19-bit tag, 16-bit word.
REQ-016 A buffer hit SHALL be defined as valid AND tag == address[19:1].
REQ-017 On a hit, rdata SHALL be word[15:8] when address[0]=1 and word[7:0] otherwise; on a miss, rdata SHALL be 8'h00.
REQ-018 The state machine SHALL have four states: IDLE, RD, WR and WDONE.
REQ-019 locked SHALL be 1 only in IDLE with wreq=0 and a hit, or in WDONE; it SHALL be 0 in every other case.
REQ-020 IDLE transitions:
  - wreq=1: latch address[19:1], lane and wdata, then go to WR; a write takes priority over a read miss.
  - wreq=0 with a miss: go to RD.
  - otherwise: remain in IDLE.
REQ-021 RD SHALL drive sram_a=address[19:1], sram_oe=1 and sram_be=2'b11 for WAIT cycles.
REQ-022 On the final RD cycle, the block SHALL load sram_dq_i into word, set tag and valid=1, and return to IDLE; a read miss therefore completes with locked=1 exactly WAIT+1 cycles after it is presented.
REQ-023 WR SHALL, for WAIT cycles, drive:
  - sram_we=1;
  - sram_a from the latched address;
  - sram_dq_o = {wdata, wdata};
  - sram_be = 2'b10 when address[0]=1, else 2'b01.
REQ-024 On the final WR cycle, if the buffer tag matches the written word, the block SHALL update only the written byte of the buffered word, leaving valid unchanged; it SHALL then go to WDONE.
REQ-025 WDONE SHALL last exactly one cycle with locked=1, then return to IDLE.
REQ-026 A second wreq=1 sampled in IDLE after WDONE SHALL be treated as a new write (consecutive low/high bytes of a 16-bit store).
REQ-027 sram_oe and sram_we SHALL never both be 1.
REQ-028 sram_oe and sram_we SHALL be 0 in IDLE and WDONE.
REQ-029 The SRAM wait counter SHALL be log2-sized for WAIT and SHALL reset to 0 on entry to RD or WR.
REQ-030 Address 20'hFFFFF SHALL map to word 19'h7FFFF, high lane; no address wrap logic SHALL exist.

Reset
REQ-031 With resetn=0 on a clock edge, the block SHALL set state=IDLE, valid=0, counter=0, sram_oe=0, sram_we=0 and sram_be=2'b00.
REQ-032 Consequently locked SHALL read 0 after reset until the first read completes.
REQ-033 A reset asserted during RD or WR SHALL abort the access, with sram_we and sram_oe low from the following cycle; the buffer SHALL NOT be updated.

Configuration
REQ-034 With macro CORE88_SRAM_ROM_EN defined, writes to addresses 20'hF0000-20'hFFFFF SHALL go directly from IDLE to WDONE with no SRAM cycle and no buffer update.
REQ-035 With CORE88_SRAM_ROM_EN undefined, the full address space SHALL be writable.

Verification
REQ-036 Reset, then read 20'hFFFF0 with SRAM word 16'hA5EA, WAIT=2 -> locked=0 for 3 cycles, then locked=1 with rdata=8'hEA.
REQ-037 Read 20'hFFFF1 immediately after REQ-036 -> buffer hit, locked=1 in the same cycle, rdata=8'hA5, no sram_oe pulse.
REQ-038 Write 8'h34 to 20'h00101 then 8'h12 to 20'h00102, WAIT=2 ->
  - two WR bursts: be=2'b10 at word 19'h00080, then be=2'b01 at word 19'h00081;
  - one WDONE locked pulse per byte.
REQ-039 Buffer holds word 19'h00080 = 16'h0000; write 8'h77 to 20'h00100 -> a subsequent read of 20'h00100 hits with rdata=8'h77 and no SRAM read.
REQ-040 With CORE88_SRAM_ROM_EN defined, write to 20'hF0010 -> sram_we stays 0 and locked=1 the next cycle; without the macro, sram_we=1 for WAIT cycles.
REQ-041 Assert resetn=0 during the second cycle of WR -> sram_we=0 on the next cycle, valid=0, locked=0.
